// File: rtl/io_input_ctrl_pkg.sv
// Shared IO word addresses (addr[7:2]), decode select and the STATUS word layout
// used by the input controller, the output-port block and the IO read mux.
package io_input_ctrl_pkg;

  localparam logic [5:0] IO_PORT0  = 6'b100000;
  localparam logic [5:0] IO_PORT1  = 6'b100001;
  localparam logic [5:0] IO_STATUS = 6'b100010;
  localparam logic [5:0] IO_CTRL   = 6'b100011;

  localparam int unsigned STAT_NEW_LSB  = 0;
  localparam int unsigned STAT_OVF_LSB  = 8;
  localparam int unsigned STAT_MASK_LSB = 16;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_PORT0,
    SEL_PORT1,
    SEL_STATUS,
    SEL_CTRL
  } io_sel_e;

  function automatic io_sel_e io_decode(input logic [5:0] word);
    case (word)
      IO_PORT0:  return SEL_PORT0;
      IO_PORT1:  return SEL_PORT1;
      IO_STATUS: return SEL_STATUS;
      IO_CTRL:   return SEL_CTRL;
      default:   return SEL_NONE;
    endcase
  endfunction

  function automatic logic [31:0] status_word(input logic [1:0] mask,
                                              input logic [1:0] ovf,
                                              input logic [1:0] nflag);
    return {14'b0, mask, 6'b0, ovf, 6'b0, nflag};
  endfunction

endpackage

// File: rtl/io_debounce.sv
// Two-flop synchroniser plus whole-word debounce: a value is accepted once the
// synchronised word has stayed unchanged for DEB_CNT+1 consecutive samples.
module io_debounce #(
  parameter int unsigned DEB_CNT = 4,
  parameter int unsigned CNT_W   = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] raw,
  output logic [31:0] stable,
  output logic        upd
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CNT - 1);

  logic [31:0]      sync1_q, sync1_d, sync2_q, sync2_d;
  logic [31:0]      cand_q, cand_d, stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // upd is decoded from registers so the flag logic sees it on the same edge
  // that stable_q takes the new value.
  always_comb begin
    sync1_d  = raw;
    sync2_d  = sync1_q;
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    stable_d = stable_q;
    upd      = 1'b0;
    if (sync2_q != cand_q) begin
      cand_d = sync2_q;
      cnt_d  = '0;
    end else if (cnt_q != CNT_LAST) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (cand_q != stable_q) begin
      stable_d = cand_q;
      upd      = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      cand_q   <= '0;
      cnt_q    <= '0;
      stable_q <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign stable = stable_q;

endmodule

// File: rtl/io_input_ctrl.sv
// Memory-mapped controller for the two debounced CPU input ports: decode, new/overrun
// flags, interrupt mask, combinational read mux and registered level irq.
module io_input_ctrl
  import io_input_ctrl_pkg::*;
#(
  parameter int unsigned DEB_CNT = 4,
  parameter int unsigned CNT_W   = 3
) (
  input  logic        io_clk,
  input  logic        resetn,
  input  logic [31:0] addr,
  input  logic        io_rd,
  input  logic        io_wr,
  input  logic [31:0] io_wdata,
  input  logic [31:0] in_port0,
  input  logic [31:0] in_port1,
  output logic [31:0] io_read_data,
  output logic        irq
);

  io_sel_e     sel;
  logic [31:0] stable0, stable1;
  logic [1:0]  upd, port_rd;
  logic [1:0]  new_q, new_d, ovf_q, ovf_d, mask_q, mask_d;
  logic        irq_q, irq_d;
  logic        ctrl_wr, clr_all;
  logic        unused_bits;

  io_debounce #(.DEB_CNT(DEB_CNT), .CNT_W(CNT_W)) u_deb0 (
    .clk(io_clk), .rst_n(resetn), .raw(in_port0), .stable(stable0), .upd(upd[0])
  );

  io_debounce #(.DEB_CNT(DEB_CNT), .CNT_W(CNT_W)) u_deb1 (
    .clk(io_clk), .rst_n(resetn), .raw(in_port1), .stable(stable1), .upd(upd[1])
  );

  assign sel         = io_decode(addr[7:2]);
  assign port_rd     = {io_rd && (sel == SEL_PORT1), io_rd && (sel == SEL_PORT0)};
  assign ctrl_wr     = io_wr && (sel == SEL_CTRL);
  assign clr_all     = ctrl_wr && io_wdata[31];
  assign unused_bits = ^{addr[31:8], addr[1:0], io_wdata[30:2]};

  // A same-edge update always wins over a read-clear or a CTRL clear.
  always_comb begin
    new_d  = new_q;
    ovf_d  = ovf_q;
    mask_d = ctrl_wr ? io_wdata[1:0] : mask_q;
    for (int unsigned i = 0; i < 2; i++) begin
      if (upd[i]) begin
        new_d[i] = 1'b1;
        if (new_q[i] && !port_rd[i]) ovf_d[i] = 1'b1;
        else if (clr_all)            ovf_d[i] = 1'b0;
      end else begin
        if (port_rd[i] || clr_all) new_d[i] = 1'b0;
        if (clr_all)               ovf_d[i] = 1'b0;
      end
    end
    irq_d = |(new_d & mask_d);
  end

  always_ff @(posedge io_clk or negedge resetn) begin
    if (!resetn) begin
      new_q  <= '0;
      ovf_q  <= '0;
      mask_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      new_q  <= new_d;
      ovf_q  <= ovf_d;
      mask_q <= mask_d;
      irq_q  <= irq_d;
    end
  end

  always_comb begin
    io_read_data = '0;
    case (sel)
      SEL_PORT0:  io_read_data = stable0;
      SEL_PORT1:  io_read_data = stable1;
      SEL_STATUS: io_read_data = status_word(mask_q, ovf_q, new_q);
      SEL_CTRL:   io_read_data = {30'b0, mask_q};
      default:    io_read_data = '0;
    endcase
  end

  assign irq = irq_q;

endmodule

// File: tb/tb_io_input_ctrl.sv
// Bench for io_input_ctrl: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a window-based reference model.
module tb_io_input_ctrl;

  logic        io_clk = 1'b0;
  logic        resetn;
  logic [31:0] addr;
  logic        io_rd;
  logic        io_wr;
  logic [31:0] io_wdata;
  logic [31:0] in_port0;
  logic [31:0] in_port1;
  logic [31:0] io_read_data;
  logic        irq;

  int n_tests = 0;
  int n_fail  = 0;

  io_input_ctrl #(.DEB_CNT(4), .CNT_W(3)) dut (
    .io_clk(io_clk), .resetn(resetn), .addr(addr), .io_rd(io_rd), .io_wr(io_wr),
    .io_wdata(io_wdata), .in_port0(in_port0), .in_port1(in_port1),
    .io_read_data(io_read_data), .irq(irq)
  );

  always #5 io_clk = ~io_clk;

  // Reference model: a word is accepted when the synchronised samples used on
  // the last 5 edges (DEB_CNT+1) are identical and differ from the held value.
  localparam int HIST = 16384;
  logic [31:0] raw_hist [2][HIST];
  int          ek;
  logic [31:0] m_stable [2];
  logic [1:0]  m_new, m_ovf, m_mask;
  logic        m_irq;

  function automatic logic [31:0] used_at(input int p, input int k);
    if (k <= 2) return 32'h0;
    return raw_hist[p][k-2];
  endfunction

  function automatic logic [31:0] exp_read(input logic [31:0] a);
    logic [5:0] w;
    w = a[7:2];
    case (w)
      6'h20:   return m_stable[0];
      6'h21:   return m_stable[1];
      6'h22:   return {14'b0, m_mask, 6'b0, m_ovf, 6'b0, m_new};
      6'h23:   return {30'b0, m_mask};
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge io_clk or negedge resetn) begin
    if (!resetn) begin
      ek = 0;
      m_stable[0] = '0; m_stable[1] = '0;
      m_new = '0; m_ovf = '0; m_mask = '0; m_irq = 1'b0;
    end else begin
      logic [1:0]  u, rd, n_new, n_ovf;
      logic [31:0] v;
      logic        same, clr, cw;
      ek++;
      if (ek >= HIST) $fatal(1, "FAIL model_history: bench history exhausted");
      raw_hist[0][ek] = in_port0;
      raw_hist[1][ek] = in_port1;
      u = '0;
      for (int p = 0; p < 2; p++) begin
        if (ek >= 4) begin
          v = used_at(p, ek);
          same = 1'b1;
          for (int j = 1; j <= 4; j++) if (used_at(p, ek - j) != v) same = 1'b0;
          if (same && v != m_stable[p]) begin
            m_stable[p] = v;
            u[p] = 1'b1;
          end
        end
      end
      rd[0] = io_rd && addr[7:2] == 6'h20;
      rd[1] = io_rd && addr[7:2] == 6'h21;
      cw    = io_wr && addr[7:2] == 6'h23;
      clr   = cw && io_wdata[31];
      n_new = m_new;
      n_ovf = m_ovf;
      for (int p = 0; p < 2; p++) begin
        if (u[p]) n_new[p] = 1'b1;
        else if (rd[p] || clr) n_new[p] = 1'b0;
        if (u[p] && m_new[p] && !rd[p]) n_ovf[p] = 1'b1;
        else if (clr) n_ovf[p] = 1'b0;
      end
      m_new = n_new;
      m_ovf = n_ovf;
      if (cw) m_mask = io_wdata[1:0];
      m_irq = |(m_new & m_mask);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge io_clk) begin
    check("model_read", io_read_data, exp_read(addr));
    check("model_irq", {31'b0, irq}, {31'b0, m_irq});
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge io_clk);
    #2;
  endtask

  task automatic peek(input string name, input logic [31:0] a, input logic [31:0] exp);
    addr = a;
    io_rd = 1'b0;
    #1;
    check(name, io_read_data, exp);
  endtask

  task automatic ctrl_write(input logic [31:0] v);
    addr = 32'h8C; io_wdata = v; io_wr = 1'b1; io_rd = 1'b0;
    cyc(1);
    io_wr = 1'b0; addr = 32'h0;
  endtask

  task automatic port_read(input logic [31:0] a);
    addr = a; io_rd = 1'b1;
    cyc(1);
    io_rd = 1'b0; addr = 32'h0;
  endtask

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 3))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h1 << $urandom_range(0, 31);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int hold0, hold1;
    resetn = 1'b0; addr = '0; io_rd = 1'b0; io_wr = 1'b0; io_wdata = '0;
    in_port0 = 32'hFFFF_FFFF; in_port1 = 32'hFFFF_FFFF;

    // 1: reset state, then power-on acceptance after 7 edges
    cyc(3);
    peek("rst_port0", 32'h80, 32'h0);
    peek("rst_port1", 32'h84, 32'h0);
    peek("rst_status", 32'h88, 32'h0);
    peek("rst_ctrl", 32'h8C, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);
    resetn = 1'b1;
    cyc(6);
    peek("rst_port0_e6", 32'h80, 32'h0);
    cyc(1);
    peek("rst_port0_e7", 32'h80, 32'hFFFF_FFFF);
    peek("rst_port1_e7", 32'h84, 32'hFFFF_FFFF);
    peek("rst_status_e7", 32'h88, 32'h0000_0003);

    // 2: latency
    in_port0 = 32'h0; in_port1 = 32'h0;
    cyc(10);
    ctrl_write(32'h8000_0000);
    in_port0 = 32'h0000_00A5;
    cyc(6);
    peek("lat_e6", 32'h80, 32'h0);
    cyc(1);
    peek("lat_e7", 32'h80, 32'h0000_00A5);

    // 3: glitch on port1
    ctrl_write(32'h8000_0000);
    in_port1 = 32'h1;
    cyc(3);
    in_port1 = 32'h0;
    cyc(10);
    peek("glitch_port1", 32'h84, 32'h0);
    peek("glitch_status", 32'h88, 32'h0);

    // 4: overrun then read-clear
    in_port0 = 32'h11;
    cyc(10);
    in_port0 = 32'h22;
    cyc(10);
    peek("ovf_status", 32'h88, 32'h0000_0101);
    port_read(32'h80);
    peek("rdclr_status", 32'h88, 32'h0000_0100);

    // 5: read on the same edge as an accepted update
    ctrl_write(32'h8000_0000);
    in_port0 = 32'h44;
    cyc(10);
    in_port0 = 32'h55;
    cyc(6);
    port_read(32'h80);
    peek("coll_status", 32'h88, 32'h0000_0001);
    peek("coll_port0", 32'h80, 32'h55);

    // 6: masked interrupt and clear
    ctrl_write(32'h8000_0000);
    ctrl_write(32'h0000_0002);
    peek("irq_ctrl", 32'h8C, 32'h2);
    in_port1 = 32'h77;
    cyc(6);
    check("irq_e6", {31'b0, irq}, 32'h0);
    cyc(1);
    check("irq_set", {31'b0, irq}, 32'h1);
    ctrl_write(32'h8000_0002);
    check("irq_clr", {31'b0, irq}, 32'h0);
    peek("irq_status", 32'h88, 32'h0002_0000);

    // randomized traffic, checked every cycle by the model compare
    hold0 = 0; hold1 = 0;
    for (int c = 0; c < 3000; c++) begin
      if (hold0 == 0) begin in_port0 = pick_val(); hold0 = $urandom_range(1, 9); end
      else hold0--;
      if (hold1 == 0) begin in_port1 = pick_val(); hold1 = $urandom_range(1, 9); end
      else hold1--;
      case ($urandom_range(0, 9))
        0, 1:    addr = 32'h80;
        2, 3:    addr = 32'h84;
        4, 5:    addr = 32'h88;
        6, 7:    addr = 32'h8C;
        8:       addr = $urandom;
        default: addr = 32'h80 | ($urandom & 32'hFFFF_FF07);
      endcase
      io_rd = ($urandom_range(0, 2) == 0);
      io_wr = ($urandom_range(0, 4) == 0);
      io_wdata = $urandom;
      if ($urandom_range(0, 3) != 0) io_wdata = io_wdata & 32'h7FFF_FFFF;
      resetn = ($urandom_range(0, 399) != 0);
      cyc(1);
    end
    resetn = 1'b1; io_rd = 1'b0; io_wr = 1'b0;
    cyc(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
